// File: rtl/cordic_fixedpoint_pkg.sv
// Shared CORDIC fixed-point definitions: info word layout and saturating negate.
package cordic_fixedpoint_pkg;

  localparam int unsigned DATA_W_DEF   = 24;
  localparam int unsigned INFO_W       = 4;
  localparam int unsigned INFO_SWAP    = 3;
  localparam int unsigned INFO_NEG_SIN = 2;
  localparam int unsigned INFO_NEG_COS = 1;

  // Negate a w-bit two's-complement value held sign-extended in 64 bits.
  // The most negative w-bit value maps to the most positive one.
  function automatic logic signed [63:0] sat_neg(input logic signed [63:0] x,
                                                 input int unsigned       w);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    return (x == -lim) ? (lim - 64'sd1) : -x;
  endfunction

endpackage

// File: rtl/cordic_fixedpoint_angledenormalize_infofifo.sv
// Circular info-word FIFO with occupancy and sticky overflow/underflow flags.
// Read is asynchronous; an empty pop yields an all-zero word.
module cordic_fixedpoint_angledenormalize_infofifo #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned INFO_W = 4
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iPush,
  input  logic [INFO_W-1:0] iPush_info,
  input  logic              iPop,
  output logic [INFO_W-1:0] oPop_info,
  output logic [ADDR_W:0]   oLevel,
  output logic              oOverflow,
  output logic              oUnderflow
);

  logic [INFO_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  // Full FIFO still accepts a push when a pop frees a slot in the same cycle;
  // no bypass, so a push never satisfies a same-cycle pop on an empty FIFO.
  always_comb begin
    empty     = (level == '0);
    full      = (level == (ADDR_W + 1)'(DEPTH));
    pop_ok    = iPop && !empty;
    push_ok   = iPush && (!full || pop_ok);
    oPop_info = pop_ok ? mem[rd_ptr] : '0;
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge iClk) begin
    if (iReset_n && push_ok)
      mem[wr_ptr] <= iPush_info;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (iPush && !push_ok)
        oOverflow <= 1'b1;
      if (iPop && empty)
        oUnderflow <= 1'b1;
    end
  end

  assign oLevel = level;

endmodule

// File: rtl/cordic_fixedpoint_angledenormalize.sv
// Rebuilds true sin/cos of the original phase from the CORDIC result and the
// buffered quadrant/octant info word (swap, then saturating negate).
module cordic_fixedpoint_angledenormalize
  import cordic_fixedpoint_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     iClk,
  input  logic                     iReset_n,
  input  logic                     iInfo_valid,
  input  logic [INFO_W-1:0]        iInfo,
  input  logic                     iCordic_valid,
  input  logic signed [DATA_W-1:0] iCordic_cos,
  input  logic signed [DATA_W-1:0] iCordic_sin,
  output logic                     oValid,
  output logic signed [DATA_W-1:0] oCos,
  output logic signed [DATA_W-1:0] oSin,
  output logic [ADDR_W:0]          oLevel,
  output logic                     oOverflow,
  output logic                     oUnderflow
);

  logic [INFO_W-1:0]        info;
  logic signed [DATA_W-1:0] sel_cos;
  logic signed [DATA_W-1:0] sel_sin;
  logic signed [DATA_W-1:0] rec_cos;
  logic signed [DATA_W-1:0] rec_sin;

  cordic_fixedpoint_angledenormalize_infofifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INFO_W (INFO_W)
  ) u_infofifo (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .iPush      (iInfo_valid),
    .iPush_info (iInfo),
    .iPop       (iCordic_valid),
    .oPop_info  (info),
    .oLevel     (oLevel),
    .oOverflow  (oOverflow),
    .oUnderflow (oUnderflow)
  );

  // Swap then conditionally negate; bit 0 of the info word is reserved.
  always_comb begin
    sel_sin = info[INFO_SWAP] ? iCordic_cos : iCordic_sin;
    sel_cos = info[INFO_SWAP] ? iCordic_sin : iCordic_cos;
    rec_sin = info[INFO_NEG_SIN] ? DATA_W'(sat_neg(64'(sel_sin), DATA_W)) : sel_sin;
    rec_cos = info[INFO_NEG_COS] ? DATA_W'(sat_neg(64'(sel_cos), DATA_W)) : sel_cos;
  end

  // Result registers: one-cycle pulse on oValid, data held between results.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      oValid <= 1'b0;
      oCos   <= '0;
      oSin   <= '0;
    end else begin
      oValid <= iCordic_valid;
      if (iCordic_valid) begin
        oCos <= rec_cos;
        oSin <= rec_sin;
      end
    end
  end

endmodule

// File: tb/tb_cordic_fixedpoint_angledenormalize.sv
// Randomised + directed bench for the angle denormalizer, checked each cycle
// against a queue-based reference model.
module tb_cordic_fixedpoint_angledenormalize;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 32;

  logic          iClk = 1'b0;
  logic          iReset_n;
  logic          iInfo_valid;
  logic [3:0]    iInfo;
  logic          iCordic_valid;
  logic [DW-1:0] iCordic_cos;
  logic [DW-1:0] iCordic_sin;
  logic          oValid;
  logic [DW-1:0] oCos;
  logic [DW-1:0] oSin;
  logic [5:0]    oLevel;
  logic          oOverflow;
  logic          oUnderflow;

  cordic_fixedpoint_angledenormalize #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (5)
  ) dut (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .iInfo_valid   (iInfo_valid),
    .iInfo         (iInfo),
    .iCordic_valid (iCordic_valid),
    .iCordic_cos   (iCordic_cos),
    .iCordic_sin   (iCordic_sin),
    .oValid        (oValid),
    .oCos          (oCos),
    .oSin          (oSin),
    .oLevel        (oLevel),
    .oOverflow     (oOverflow),
    .oUnderflow    (oUnderflow)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [3:0]    q[$];
  logic          m_valid;
  logic [DW-1:0] m_cos, m_sin;
  logic          m_ovf, m_unf;
  int            m_level;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Negate as a true integer, clamping the one out-of-range result.
  function automatic logic [DW-1:0] apply_neg(input logic [DW-1:0] v, input bit n);
    longint x;
    x = longint'($signed(v));
    if (n) begin
      x = -x;
      if (x > 64'sd8388607) x = 64'sd8388607;
    end
    return DW'(x);
  endfunction

  // Model step for the inputs sampled at the clock edge just passed.
  task automatic model_step();
    int         n0;
    logic [3:0] w;
    logic [DW-1:0] s1, c1;
    if (!iReset_n) begin
      q.delete();
      m_valid = 1'b0;
      m_cos   = '0;
      m_sin   = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      n0 = q.size();
      m_valid = iCordic_valid;
      if (iCordic_valid) begin
        if (n0 > 0) w = q.pop_front();
        else begin
          w = 4'b0000;
          m_unf = 1'b1;
        end
        s1 = w[3] ? iCordic_cos : iCordic_sin;
        c1 = w[3] ? iCordic_sin : iCordic_cos;
        m_sin = apply_neg(s1, w[2]);
        m_cos = apply_neg(c1, w[1]);
      end
      if (iInfo_valid) begin
        if (n0 < DEPTH || (iCordic_valid && n0 > 0)) q.push_back(iInfo);
        else m_ovf = 1'b1;
      end
    end
    m_level = q.size();
  endtask

  task automatic cyc(input bit rst_n, input bit push, input logic [3:0] info,
                     input bit pop, input logic [DW-1:0] c, input logic [DW-1:0] s);
    iReset_n      = rst_n;
    iInfo_valid   = push;
    iInfo         = info;
    iCordic_valid = pop;
    iCordic_cos   = c;
    iCordic_sin   = s;
    @(posedge iClk);
    #1;
    model_step();
    chk_en = 1'b1;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge iClk) begin
    if (chk_en) begin
      chk("oValid", 64'(oValid), 64'(m_valid));
      chk("oCos", 64'(oCos), 64'(m_cos));
      chk("oSin", 64'(oSin), 64'(m_sin));
      chk("oLevel", 64'(oLevel), 64'(m_level));
      chk("oOverflow", 64'(oOverflow), 64'(m_ovf));
      chk("oUnderflow", 64'(oUnderflow), 64'(m_unf));
    end
  end

  initial begin
    iReset_n = 1'b0; iInfo_valid = 1'b0; iInfo = '0;
    iCordic_valid = 1'b0; iCordic_cos = '0; iCordic_sin = '0;

    // Reset
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_cos", 64'(oCos), 64'd0);
    chk("rst_level", 64'(oLevel), 64'd0);
    chk("rst_flags", 64'({oOverflow, oUnderflow}), 64'd0);

    // Pass-through
    cyc(1, 1, 4'b0000, 0, 0, 0);
    cyc(1, 0, 0, 1, 24'h2D413C, 24'h2D413C);
    chk("pt_valid", 64'(oValid), 64'd1);
    chk("pt_cos", 64'(oCos), 64'h2D413C);
    chk("pt_sin", 64'(oSin), 64'h2D413C);
    chk("pt_level", 64'(oLevel), 64'd0);

    // Swap + negate sine
    cyc(1, 1, 4'b1100, 0, 0, 0);
    cyc(1, 0, 0, 1, 24'h001000, 24'h003000);
    chk("swap_sin", 64'(oSin), 64'hFFF000);
    chk("swap_cos", 64'(oCos), 64'h003000);

    // Saturating negate of cosine
    cyc(1, 1, 4'b0010, 0, 0, 0);
    cyc(1, 0, 0, 1, 24'h800000, 24'h000100);
    chk("sat_cos", 64'(oCos), 64'h7FFFFF);
    chk("sat_sin", 64'(oSin), 64'h000100);
    cyc(1, 0, 0, 0, 0, 0);
    chk("hold_valid", 64'(oValid), 64'd0);
    chk("hold_cos", 64'(oCos), 64'h7FFFFF);

    // Fill past full, wrapping pointers
    for (int i = 0; i < 33; i++) cyc(1, 1, 4'(i), 0, 0, 0);
    chk("full_level", 64'(oLevel), 64'd32);
    chk("full_ovf", 64'(oOverflow), 64'd1);
    cyc(1, 1, 4'b0110, 1, 24'h000001, 24'h000002);
    chk("full_pp_level", 64'(oLevel), 64'd32);
    chk("full_pp_cos", 64'(oCos), 64'h000001);
    chk("full_pp_sin", 64'(oSin), 64'h000002);
    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 1, 24'h000123, 24'h000456);
    chk("drain_level", 64'(oLevel), 64'd0);

    // Underflow with simultaneous push (no bypass)
    cyc(1, 1, 4'b1000, 1, 24'h111111, 24'h222222);
    chk("unf_cos", 64'(oCos), 64'h111111);
    chk("unf_sin", 64'(oSin), 64'h222222);
    chk("unf_flag", 64'(oUnderflow), 64'd1);
    chk("unf_level", 64'(oLevel), 64'd1);
    cyc(1, 0, 0, 1, 24'h000010, 24'h000020);
    chk("unf_pop_cos", 64'(oCos), 64'h000020);

    // Reset mid-stream discards buffered words
    cyc(1, 1, 4'b1110, 0, 0, 0);
    cyc(1, 1, 4'b1110, 0, 0, 0);
    cyc(1, 1, 4'b1110, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("mid_rst_level", 64'(oLevel), 64'd0);
    chk("mid_rst_flags", 64'({oOverflow, oUnderflow}), 64'd0);
    cyc(1, 0, 0, 1, 24'h0ABCDE, 24'h012345);
    chk("post_rst_unf", 64'(oUnderflow), 64'd1);
    chk("post_rst_cos", 64'(oCos), 64'h0ABCDE);
    chk("post_rst_sin", 64'(oSin), 64'h012345);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      bit rst_n, push, pop;
      logic [DW-1:0] c, s;
      rst_n = ($urandom_range(0, 299) != 0);
      push  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 40));
      pop   = ($urandom_range(0, 99) < 50);
      c     = ($urandom_range(0, 7) == 0) ? 24'h800000 : DW'($urandom);
      s     = ($urandom_range(0, 7) == 0) ? 24'h800000 : DW'($urandom);
      cyc(rst_n, push, 4'($urandom), pop, c, s);
    end

    cyc(1, 0, 0, 0, 0, 0);
    @(negedge iClk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_fixedpoint_angledenormalize.md
Name: cordic_fixedpoint_angledenormalize

Overview:
Output-side counterpart of the angle normalizer. It buffers the 4-bit quadrant/octant info word produced for each normalized phase while the CORDIC core iterates. When the core returns cos/sin of the normalized angle, the block pops the matching info word and applies swap and negation to rebuild the true sine/cosine of the original 24-bit phase. It sits between the CORDIC rotation pipeline output and the top-level result port.

Parameters:
DATA_W, 24, signed two's-complement width of the CORDIC cos/sin results and of the outputs
DEPTH, 32, info FIFO depth; power of two; must be >= the number of phases that can be in flight in the CORDIC core
ADDR_W, 5, log2(DEPTH)

Ports:
iClk  in  1  clock
iReset_n  in  1  synchronous active-low reset
iInfo_valid  in  1  push strobe; arrives aligned with the normalizer's registered phase-valid output
iInfo  in  4  info word: [3] swap sin/cos, [2] negate sine, [1] negate cosine, [0] reserved (stored, ignored)
iCordic_valid  in  1  CORDIC result strobe; pops one info word
iCordic_cos  in  DATA_W  signed cos of the normalized angle
iCordic_sin  in  DATA_W  signed sin of the normalized angle
oValid  out  1  result strobe
oCos  out  DATA_W  reconstructed cosine
oSin  out  DATA_W  reconstructed sine
oLevel  out  ADDR_W+1  current FIFO occupancy
oOverflow  out  1  sticky: a push was dropped
oUnderflow  out  1  sticky: a result arrived with no info word available

Behaviour:
- Reset: iReset_n sampled on the rising edge of iClk, synchronous, active-low. All outputs clear to 0, and the FIFO pointers and level clear to 0. FIFO RAM contents are not reset. Reset mid-operation discards all in-flight info words; outputs are 0 in the cycle after the reset edge.
- FIFO: circular buffer with wr_ptr/rd_ptr of ADDR_W bits, wrapping DEPTH-1 -> 0. Level counter is ADDR_W+1 bits; full is level==DEPTH, empty is level==0.
- Push (iInfo_valid):
  - Not full: write iInfo at wr_ptr, then advance wr_ptr.
  - Full and no simultaneous pop: drop the word, set oOverflow, leave level unchanged.
  - Full with simultaneous pop: accept the push; level stays DEPTH.
- Pop (iCordic_valid):
  - Not empty: read the word at rd_ptr, then advance rd_ptr.
  - Empty: use info=4'b0000 (pass-through), set oUnderflow, leave pointers unchanged.
  - No bypass: a push in the same cycle as a pop on an empty FIFO does not satisfy that pop. That cycle counts as an underflow, and the pushed word is stored.
- Level update: +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither occur.
- Reconstruction (combinational from the popped word and iCordic_*):
  - Swap stage: s' = swap ? cos : sin; c' = swap ? sin : cos.
  - oSin = neg_sin ? -s' : s'; oCos = neg_cos ? -c' : c'.
  - Negation saturates: -(-2^(DATA_W-1)) yields 2^(DATA_W-1)-1.
- Latency: oValid, oCos and oSin are registered one cycle after iCordic_valid. oValid is a single-cycle pulse per input strobe, so back-to-back results give back-to-back oValid. oCos/oSin hold their last values when oValid=0.
- FIFO read is asynchronous (distributed RAM) so the popped word is available in the same cycle.
- oOverflow and oUnderflow stay set until reset.

Decomposition:
- Shared package cordic_fixedpoint_pkg holds:
  - info bit indices: INFO_SWAP=3, INFO_NEG_SIN=2, INFO_NEG_COS=1
  - INFO_W=4
  - DATA_W default
  - the saturating-negate function
- The normalizer's info encoding is taken from the same package.
- One sub-module: cordic_fixedpoint_angledenormalize_infofifo, which owns the pointers, level, full/empty and flags. The top level holds the swap/negate datapath and output registers.

Test Plan:
- Reset, then push info 4'b0000, then cordic cos=0x2D413C, sin=0x2D413C -> next cycle oValid=1, oCos=0x2D413C, oSin=0x2D413C, oLevel back to 0.
- Push 4'b1100, then cos=0x001000, sin=0x003000 -> oSin=0xFFF000, oCos=0x003000.
- Push 4'b0010, then cos=0x800000, sin=0x000100 -> oCos=0x7FFFFF (saturated), oSin=0x000100.
- Push 33 words with no pops -> oLevel=32, oOverflow=1. Then 32 pops return words 0..31 in order across the pointer wrap. An extra push and pop in the same cycle while full leaves oLevel=32.
- iCordic_valid with empty FIFO and a simultaneous push of 4'b1000 -> pass-through output, oUnderflow=1, oLevel=1.
- Stream 3 pushes, assert reset for 1 cycle, then pop -> oLevel=0 after reset, and the pop flags oUnderflow with pass-through data.
